// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and the queued command record.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 3;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundles the local command/response port and the APB bus of the bridge.
// The master modport is the bridge's view, the slave modport is the surrounding environment's.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO without bypass; pointers carry one extra wrap bit to tell full
// from empty.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  apb_cmd_t push_data,
    output logic     full,
    input  logic     pop,
    output apb_cmd_t pop_data,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

    apb_cmd_t       mem [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Queues local read/write commands and replays them as APB SETUP/ACCESS transfers, returning
// one response pulse per transfer. Define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic                 pclk,
    input logic                 preset_n,
    apb_master_bridge_if.master bus
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_master_bridge: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end
    if (ADDR_W != APB_ADDR_W || DATA_W != APB_DATA_W) begin : g_bad_width
        $error("apb_master_bridge: ADDR_W/DATA_W must match the apb_cmd_t field widths");
    end

    apb_state_e        state_q;
    logic              pselx_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    apb_cmd_t          new_cmd;
    apb_cmd_t          head_cmd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              xfer_done;
    logic              timeout;

    assign new_cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};

    apb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (pclk),
        .rst_n     (preset_n),
        .push      (bus.cmd_valid),
        .push_data (new_cmd),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head_cmd),
        .empty     (fifo_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitOne = {{(WaitW - 1){1'b0}}, 1'b1};

    logic [WaitW-1:0] wait_cnt_q;

    // The wait cycle that brings the count to TIMEOUT_CYCLES is the one that ends the transfer.
    assign timeout = (state_q == ACCESS) && !bus.pready && (wait_cnt_q == WaitLast);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS && !bus.pready) begin
            wait_cnt_q <= wait_cnt_q + WaitOne;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        xfer_done = (state_q == ACCESS) && (bus.pready || timeout);
        pop       = !fifo_empty && ((state_q == IDLE) || xfer_done);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        paddr_q  <= head_cmd.addr;
                        pwrite_q <= head_cmd.write;
                        pwdata_q <= head_cmd.wdata;
                        pselx_q  <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pready ? bus.pslverr : 1'b1;
                        rsp_rdata_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
                        penable_q   <= 1'b0;
                        // Chain straight into the next SETUP so a busy queue never idles the bus.
                        if (pop) begin
                            paddr_q  <= head_cmd.addr;
                            pwrite_q <= head_cmd.write;
                            pwdata_q <= head_cmd.wdata;
                            state_q  <= SETUP;
                        end else begin
                            pselx_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    pselx_q   <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.pselx     = pselx_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: an APB slave model with scripted wait states and errors, and a
// command-level reference model predicting every response.
module tb_apb_master_bridge;

    localparam int unsigned TIMEOUT = 15;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef struct {
        int waits;
        bit err;
    } xfer_cfg_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } rsp_t;

    logic pclk = 1'b0;
    logic preset_n = 1'b1;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    apb_master_bridge #(
        .ADDR_W         (3),
        .DATA_W         (8),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushed = 0;
    int setups = 0;
    int ready_bad = 0;
    int ready_low_seen = 0;
    int last_accept = 0;

    xfer_cfg_t  cfg_q[$];
    rsp_t       exp_q[$];
    rsp_t       rsp_q[$];
    int         setup_q[$];
    logic [7:0] smem[8];
    logic [7:0] mmem[8];

    always @(posedge pclk) cyc <= cyc + 1;

    // APB slave: takes per-transfer wait/error settings in order; junk outside ACCESS.
    initial begin : slave
        xfer_cfg_t cur;
        int left;
        bit in_acc;
        cur = '{0, 1'b0};
        left = 0;
        in_acc = 1'b0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                in_acc = 1'b0;
                bus.pready = 1'b0;
                bus.prdata = 8'h00;
                bus.pslverr = 1'b0;
            end else if (bus.pselx && bus.penable) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    cur = (cfg_q.size() > 0) ? cfg_q.pop_front() : '{0, 1'b0};
                    left = cur.waits;
                end
                if (left > 0) begin
                    left--;
                    bus.pready = 1'b0;
                    bus.prdata = 8'($urandom);
                    bus.pslverr = 1'($urandom);
                end else begin
                    bus.pready = 1'b1;
                    bus.pslverr = cur.err;
                    bus.prdata = bus.pwrite ? 8'($urandom) : smem[bus.paddr];
                    if (bus.pwrite) smem[bus.paddr] = bus.pwdata;
                    in_acc = 1'b0;
                end
            end else begin
                in_acc = 1'b0;
                bus.pready = 1'($urandom);
                bus.prdata = 8'($urandom);
                bus.pslverr = 1'($urandom);
            end
        end
    end

    // Records responses and SETUP cycles; tracks cmd_ready against queued = pushed - popped.
    initial begin : monitor
        forever begin
            @(negedge pclk);
            if (preset_n) begin
                if (bus.rsp_valid) rsp_q.push_back('{bus.rsp_rdata, bus.rsp_err, cyc});
                if (bus.pselx && !bus.penable) begin
                    setups++;
                    setup_q.push_back(cyc);
                end
                if (bus.cmd_ready !== ((pushed - setups) < 4)) ready_bad++;
                if (!bus.cmd_ready) ready_low_seen++;
            end
        end
    end

    task automatic push_cmd(input bit wr, input logic [2:0] addr, input logic [7:0] wdata,
                            input int waits, input bit err);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr = addr;
        bus.cmd_wdata = wdata;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge pclk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_wait: cmd_ready stayed %b, required 1", bus.cmd_ready);
        end
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr = 3'($urandom);
        bus.cmd_wdata = 8'($urandom);
        pushed++;
        last_accept = cyc;
        cfg_q.push_back('{waits, err});
        if (TimeoutEn && waits >= int'(TIMEOUT)) begin
            exp_q.push_back('{8'h00, 1'b1, 0});
        end else if (wr) begin
            exp_q.push_back('{8'h00, err, 0});
            mmem[addr] = wdata;
        end else begin
            exp_q.push_back('{mmem[addr], err, 0});
        end
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        int k = 0;
        while (rsp_q.size() < n && k < 300) begin
            @(negedge pclk);
            #1;
            k++;
        end
        ok = (rsp_q.size() >= n);
    endtask

    task automatic test_reset();
        #1 preset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
             bus.rsp_err, bus.rsp_rdata} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b re=%b rd=%h, required all 0",
                     bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
                     bus.rsp_err, bus.rsp_rdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", bus.cmd_ready);
        end
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_write_read();
        rsp_t r, e;
        bit ok;
        int acc;
        push_cmd(1'b1, 3'd5, 8'hA5, 0, 1'b0);
        acc = last_accept;
        @(posedge pclk);
        #1;
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata} !== {3'b101, 3'd5, 8'hA5}) begin
            errors++;
            $display("FAIL wr_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, required 1 0 1 5 a5",
                     bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
        end
        @(posedge pclk);
        #1;
        checks++;
        if ({bus.pselx, bus.penable} !== 2'b11) begin
            errors++;
            $display("FAIL wr_access: got psel=%b pen=%b, required 1 1", bus.pselx, bus.penable);
        end
        wait_rsp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_rsp_timeout: got %0d responses, required 1", rsp_q.size());
        end else begin
            r = rsp_q.pop_front();
            e = exp_q.pop_front();
            if (r.rdata !== 8'h00 || r.err !== 1'b0 || r.cyc != acc + 3) begin
                errors++;
                $display("FAIL wr_rsp: got rdata=%h err=%b at +%0d, required 00 0 at +3",
                         r.rdata, r.err, r.cyc - acc);
            end
        end
        push_cmd(1'b0, 3'd5, 8'h00, 0, 1'b0);
        wait_rsp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd_rsp_timeout: got %0d responses, required 1", rsp_q.size());
        end else begin
            r = rsp_q.pop_front();
            e = exp_q.pop_front();
            if (r.rdata !== 8'hA5 || r.err !== e.err) begin
                errors++;
                $display("FAIL rd_rsp: got rdata=%h err=%b, required a5 %b", r.rdata, r.err, e.err);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t r, e;
        bit ok;
        setup_q.delete();
        ready_bad = 0;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 3'($urandom), 8'($urandom), 0, 1'b0);
        wait_rsp(4, ok);
        checks++;
        if (!ok || setup_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses %0d setups, required 4 4",
                     rsp_q.size(), setup_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                r = rsp_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got rdata=%h err=%b, required %h %b",
                             i, r.rdata, r.err, e.rdata, e.err);
                end
                if (i > 0) begin
                    checks++;
                    if (setup_q[i] - setup_q[i-1] != 2) begin
                        errors++;
                        $display("FAIL b2b_cadence%0d: got %0d cycles, required 2",
                                 i, setup_q[i] - setup_q[i-1]);
                    end
                end
            end
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL b2b_ready: got %0d bad cmd_ready cycles, required 0", ready_bad);
        end
    endtask

    task automatic test_fifo_full();
        rsp_t r, e;
        bit ok;
        ready_bad = 0;
        ready_low_seen = 0;
        push_cmd(1'b0, 3'($urandom), 8'h00, 6, 1'b0);
        for (int i = 0; i < 5; i++)
            push_cmd(1'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 2), 1'($urandom));
        wait_rsp(6, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_count: got %0d responses, required 6", rsp_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                r = rsp_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL full_rsp%0d: got rdata=%h err=%b, required %h %b",
                             i, r.rdata, r.err, e.rdata, e.err);
                end
            end
        end
        checks++;
        if (ready_bad != 0 || ready_low_seen == 0) begin
            errors++;
            $display("FAIL full_ready: got %0d bad / %0d low cycles, required 0 bad and >0 low",
                     ready_bad, ready_low_seen);
        end
    endtask

    task automatic test_wait_states();
        rsp_t r, e;
        bit ok, seen, done;
        int n, acc_cycles, stable_bad, ready_cyc;
        logic [2:0] a0;
        logic w0;
        seen = 0; done = 0; n = 0; acc_cycles = 0; stable_bad = 0; ready_cyc = 0;
        a0 = 3'd0; w0 = 1'b0;
        push_cmd(1'b0, 3'd2, 8'h00, 3, 1'b0);
        while (!done && n < 50) begin
            @(negedge pclk);
            #2;
            n++;
            if (bus.pselx && bus.penable) begin
                acc_cycles++;
                if (!seen) begin
                    seen = 1;
                    a0 = bus.paddr;
                    w0 = bus.pwrite;
                end else if (bus.paddr !== a0 || bus.pwrite !== w0) begin
                    stable_bad++;
                end
                if (bus.pready) begin
                    done = 1;
                    ready_cyc = cyc;
                end
            end else if (seen) begin
                stable_bad++;
            end
        end
        checks++;
        if (acc_cycles != 4 || stable_bad != 0 || a0 !== 3'd2 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL wait_access: got %0d cycles %0d unstable addr=%h wr=%b, required 4 0 2 0",
                     acc_cycles, stable_bad, a0, w0);
        end
        wait_rsp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_rsp_timeout: got %0d responses, required 1", rsp_q.size());
        end else begin
            r = rsp_q.pop_front();
            e = exp_q.pop_front();
            if (r.rdata !== e.rdata || r.err !== e.err || r.cyc != ready_cyc + 1) begin
                errors++;
                $display("FAIL wait_rsp: got rdata=%h err=%b at +%0d, required %h %b at +1",
                         r.rdata, r.err, r.cyc - ready_cyc, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_slave_error();
        rsp_t r0, r1;
        bit ok;
        push_cmd(1'b1, 3'd7, 8'($urandom), 0, 1'b1);
        push_cmd(1'b1, 3'($urandom), 8'($urandom), 0, 1'b0);
        wait_rsp(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err_count: got %0d responses, required 2", rsp_q.size());
        end else begin
            r0 = rsp_q.pop_front();
            r1 = rsp_q.pop_front();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            checks++;
            if (r0.err !== 1'b1 || r1.err !== 1'b0 || r0.rdata !== 8'h00) begin
                errors++;
                $display("FAIL err_flag: got err=%b,%b rdata=%h, required 1,0 00",
                         r0.err, r1.err, r0.rdata);
            end
        end
    endtask

    task automatic test_random();
        rsp_t r, e;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            push_cmd(1'($urandom), 3'($urandom), 8'($urandom), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            #1;
        end
        wait_rsp(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rand_count: got %0d responses, required 20", rsp_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                r = rsp_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL rand_rsp%0d: got rdata=%h err=%b, required %h %b",
                             i, r.rdata, r.err, e.rdata, e.err);
                end
            end
        end
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        rsp_t r, e;
        bit ok;
        push_cmd(1'b0, 3'($urandom), 8'h00, 1000, 1'b0);
        push_cmd(1'b0, 3'($urandom), 8'h00, 0, 1'b0);
        wait_rsp(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_count: got %0d responses, required 2", rsp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                r = rsp_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (r.rdata !== e.rdata || r.err !== e.err) begin
                    errors++;
                    $display("FAIL to_rsp%0d: got rdata=%h err=%b, required %h %b",
                             i, r.rdata, r.err, e.rdata, e.err);
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        rsp_t r, e;
        bit ok;
        int n = 0;
        push_cmd(1'b0, 3'($urandom), 8'h00, 20, 1'b0);
        push_cmd(1'b0, 3'($urandom), 8'h00, 0, 1'b0);
        push_cmd(1'b0, 3'($urandom), 8'h00, 0, 1'b0);
        while (!(bus.pselx && bus.penable) && n < 20) begin
            @(negedge pclk);
            #2;
            n++;
        end
        @(negedge pclk);
        #2 preset_n = 1'b0;
        #1;
        checks++;
        if ({bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid,
             bus.rsp_err, bus.rsp_rdata, bus.cmd_ready} !== 24'd1) begin
            errors++;
            $display("FAIL mid_reset_outputs: got psel=%b pen=%b paddr=%h rv=%b ready=%b, required 0 0 0 0 1",
                     bus.pselx, bus.penable, bus.paddr, bus.rsp_valid, bus.cmd_ready);
        end
        repeat (2) @(negedge pclk);
        cfg_q.delete();
        exp_q.delete();
        rsp_q.delete();
        pushed = 0;
        setups = 0;
        preset_n = 1'b1;
        repeat (10) @(negedge pclk);
        #1;
        checks++;
        if (rsp_q.size() != 0 || setups != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %0d responses %0d setups, required 0 0",
                     rsp_q.size(), setups);
        end
        push_cmd(1'b0, 3'($urandom), 8'h00, 1, 1'b0);
        wait_rsp(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reset_resume: got %0d responses, required 1", rsp_q.size());
        end else begin
            r = rsp_q.pop_front();
            e = exp_q.pop_front();
            if (r.rdata !== e.rdata || r.err !== e.err) begin
                errors++;
                $display("FAIL mid_reset_rsp: got rdata=%h err=%b, required %h %b",
                         r.rdata, r.err, e.rdata, e.err);
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = 3'd0;
        bus.cmd_wdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            smem[i] = 8'($urandom);
            mmem[i] = smem[i];
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fifo_full();
        test_wait_states();
        test_slave_error();
        test_random();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester that sits directly in front of the 8-entry × 8-bit APB slave. It accepts simple read/write commands from a local requester into a small command FIFO. It converts each command into a compliant APB SETUP→ACCESS transfer and waits on `pready`. For every completed transfer it returns one single-cycle response carrying read data and an error flag.

## Interface
- `ADDR_W`, 3: APB address width; matches slave register-file index.
- `DATA_W`, 8: APB data width.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 15: maximum ACCESS wait cycles with `pready` low. Used only when `APB_MASTER_TIMEOUT_EN` is defined.
- `pclk` in 1: the single clock; all logic on rising edge.
- `preset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals !full.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse per completed transfer; no backpressure.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_err` out 1: `pslverr` sampled at completion, or timeout.
- `pselx`, `penable`, `pwrite` out 1 each: APB controls.
- `paddr` out ADDR_W, `pwdata` out DATA_W: APB address and write data.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB returns.

## Operation
- Enqueue on the edge where `cmd_valid && cmd_ready`. No enqueue is possible when full.
- Simultaneous push and pop when not full is legal; count is unchanged.
- The FIFO has no bypass: a command is popped at least one cycle after it is pushed.
- FSM states are IDLE, SETUP and ACCESS. All APB outputs are registered.
- IDLE: `pselx=0`, `penable=0`. If the FIFO is non-empty, pop, load `paddr`/`pwrite`/`pwdata`, and go to SETUP.
- SETUP: `pselx=1`, `penable=0`. Always go to ACCESS on the next edge.
- ACCESS: `pselx=1`, `penable=1`. `paddr`, `pwrite` and `pwdata` stay stable.
  - While `pready=0`, remain in ACCESS.
  - On `pready=1`, complete the transfer. Next edge: `rsp_valid=1`, `rsp_err=pslverr`, `rsp_rdata = pwrite ? 0 : prdata`.
  - After completion, if the FIFO is non-empty, pop and go to SETUP (`pselx` stays high, `penable` drops). Otherwise go to IDLE.
- `paddr`, `pwrite` and `pwdata` hold their last values in IDLE.
- Reset values: `pselx`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_err` and `rsp_rdata` are all 0. `cmd_ready=1`, FIFO empty, state IDLE.
- Reset mid-transfer: the in-flight transfer and all queued commands are dropped, with no response.

## Timing
- Command accepted at edge E0 into an empty, idle bridge:
  - E1: SETUP visible.
  - E2: ACCESS visible.
  - If `pready` is high in the E2 cycle, `rsp_valid` is high after E3.
- Minimum latency is 3 cycles from accept to response.
- A zero-wait transfer occupies the bus for 2 cycles.
- Back-to-back queued commands: one transfer every 2 cycles, with no IDLE cycle between them.
- `pready`, `prdata` and `pslverr` are sampled only in ACCESS. Values in other states are ignored.
- `cmd_ready` deasserts on the edge that makes the count reach `FIFO_DEPTH`. It reasserts on the edge of the next pop.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready=0`.
  - When it reaches `TIMEOUT_CYCLES` with `pready` still low, the transfer ends.
  - Response: `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`, then the normal next-state rule.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- `APB_MASTER_TIMEOUT_EN` undefined: there is no counter. ACCESS waits indefinitely, and `rsp_err` reflects only `pslverr`.

## Structure
- Package `apb_pkg`:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS}, 2-bit.
  - `apb_cmd_t` packed struct {write, addr, wdata}.
  - Default width localparams `APB_ADDR_W=3`, `APB_DATA_W=8`.
- Sub-module `apb_cmd_fifo`: synchronous FIFO of `apb_cmd_t`.
  - Ports: push/pop/full/empty.
  - Pointers one bit wider than log2 depth for full/empty distinction.
  - Resets to empty.
- The top level holds the FSM, APB output registers, response registers and the optional timeout counter.

## Test plan
- Write then read, zero-wait: write addr 5 data 0xA5, then read addr 5. Expect:
  - Write response `rsp_valid`, `rsp_rdata=0`, `rsp_err=0`.
  - Read response `rsp_rdata=0xA5`.
  - First response 3 cycles after accept.
- Back-to-back: 4 writes pushed in 4 consecutive cycles. Expect:
  - `cmd_ready` low only while 4 entries are held.
  - 4 transfers at a 2-cycle cadence, with `pselx` continuously high.
  - 4 `rsp_valid` pulses.
- Wait states: `pready` held low for 3 ACCESS cycles on read addr 2. Expect:
  - `paddr`, `pwrite` and `penable` stable throughout.
  - Response one cycle after `pready` rises.
- Slave error: `pslverr=1` with `pready` on a write to addr 7. Expect `rsp_err=1` for exactly that response, then 0 on the next.
- Timeout (macro defined): `pready` never asserted. Expect `rsp_valid` with `rsp_err=1` and `rsp_rdata=0` after 15 wait cycles, followed by the bridge proceeding to the next queued command.
- Reset mid-ACCESS with 2 commands queued. Expect:
  - All outputs 0 immediately; `cmd_ready=1`.
  - No response pulses after reset release.
  - A new command proceeds normally.
